axi4_lite_slave_regfile: RTL and testbench

AXI4-Lite responder (slave end) exposing NUM_REGS memory-mapped 32-bit registers. It accepts write address and write data on independent channels in either order, applies byte strobes, and returns a write response. It serves reads with one outstanding transaction per direction and flags out-of-range addresses with SLVERR. It sits behind the existing AXI4-Lite master in axi4_lite_top as the register target.

---
 rtl/axi4_lite_slave_regfile.sv | 169 ++++++++++++++++
 tb/tb_axi4_lite_slave_regfile.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite register-file responder: NUM_REGS x 32-bit registers with byte
// strobes, AW/W accepted in either order, one outstanding read and one
// outstanding write, SLVERR for addresses beyond the register window.
module axi4_lite_slave_regfile #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDRESS    = 32,
   parameter int NUM_REGS   = 16
) (
   input  logic                      ACLK,
   input  logic                      ARESETN,
   input  logic [ADDRESS-1:0]        S_AWADDR,
   input  logic                      S_AWVALID,
   output logic                      S_AWREADY,
   input  logic [DATA_WIDTH-1:0]     S_WDATA,
   input  logic [DATA_WIDTH/8-1:0]   S_WSTRB,
   input  logic                      S_WVALID,
   output logic                      S_WREADY,
   output logic [1:0]                S_BRESP,
   output logic                      S_BVALID,
   input  logic                      S_BREADY,
   input  logic [ADDRESS-1:0]        S_ARADDR,
   input  logic                      S_ARVALID,
   output logic                      S_ARREADY,
   output logic [DATA_WIDTH-1:0]     S_RDATA,
   output logic [1:0]                S_RRESP,
   output logic                      S_RVALID,
   input  logic                      S_RREADY
);
   localparam int IDX_W  = $clog2(NUM_REGS);
   localparam int STRB_W = DATA_WIDTH / 8;

   typedef enum logic {WR_ACCEPT, WR_RESP} wr_state_t;

   wr_state_t               wr_state;
   logic                    ready_en;
   logic                    aw_held;
   logic                    w_held;
   logic [ADDRESS-1:0]      aw_reg;
   logic [DATA_WIDTH-1:0]   w_data_reg;
   logic [STRB_W-1:0]       w_strb_reg;
   logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

   logic                    aw_hs;
   logic                    w_hs;
   logic                    ar_hs;
   logic                    wr_commit;
   logic [ADDRESS-1:0]      wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [STRB_W-1:0]       wr_strb;
   logic                    wr_in_range;
   logic [IDX_W-1:0]        wr_idx;
   logic                    rd_in_range;
   logic [IDX_W-1:0]        rd_idx;
   logic                    unused_addr_bits;

   // Address is inside the register window when every bit above the index is zero.
   function automatic logic addr_in_range(input logic [ADDRESS-1:0] a);
      return (a[ADDRESS-1:IDX_W+2] == '0);
   endfunction

   // Merge new bytes into the old word wherever the strobe bit is set.
   function automatic logic [DATA_WIDTH-1:0] apply_strb(
      input logic [DATA_WIDTH-1:0] old_v,
      input logic [DATA_WIDTH-1:0] new_v,
      input logic [STRB_W-1:0]     strb
   );
      logic [DATA_WIDTH-1:0] r;
      r = old_v;
      for (int b = 0; b < STRB_W; b++) begin
         if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      end
      return r;
   endfunction

   assign S_AWREADY = ready_en & (wr_state == WR_ACCEPT) & ~aw_held;
   assign S_WREADY  = ready_en & (wr_state == WR_ACCEPT) & ~w_held;
   assign S_ARREADY = ready_en & ~S_RVALID;

   assign aw_hs = S_AWVALID & S_AWREADY;
   assign w_hs  = S_WVALID & S_WREADY;
   assign ar_hs = S_ARVALID & S_ARREADY;

   // Address and data may come from the holding registers or straight off the bus.
   assign wr_addr     = aw_held ? aw_reg : S_AWADDR;
   assign wr_data     = w_held ? w_data_reg : S_WDATA;
   assign wr_strb     = w_held ? w_strb_reg : S_WSTRB;
   assign wr_commit   = (wr_state == WR_ACCEPT) & (aw_held | aw_hs) & (w_held | w_hs);
   assign wr_in_range = addr_in_range(wr_addr);
   assign wr_idx      = wr_addr[2 +: IDX_W];
   assign rd_in_range = addr_in_range(S_ARADDR);
   assign rd_idx      = S_ARADDR[2 +: IDX_W];

   // Byte offset within a word is ignored on both channels.
   assign unused_addr_bits = ^{wr_addr[1:0], S_ARADDR[1:0]};

   // Keep all READY outputs low for the first edge after reset release.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) ready_en <= 1'b0;
      else          ready_en <= 1'b1;
   end

   // Write FSM: collect AW and W in any order, commit, then hold B until taken.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_state   <= WR_ACCEPT;
         aw_held    <= 1'b0;
         w_held     <= 1'b0;
         aw_reg     <= '0;
         w_data_reg <= '0;
         w_strb_reg <= '0;
         S_BVALID   <= 1'b0;
         S_BRESP    <= 2'b00;
      end else begin
         case (wr_state)
            WR_ACCEPT: begin
               if (wr_commit) begin
                  aw_held  <= 1'b0;
                  w_held   <= 1'b0;
                  S_BVALID <= 1'b1;
                  S_BRESP  <= wr_in_range ? 2'b00 : 2'b10;
                  wr_state <= WR_RESP;
               end else begin
                  if (aw_hs) begin
                     aw_reg  <= S_AWADDR;
                     aw_held <= 1'b1;
                  end
                  if (w_hs) begin
                     w_data_reg <= S_WDATA;
                     w_strb_reg <= S_WSTRB;
                     w_held     <= 1'b1;
                  end
               end
            end
            WR_RESP: begin
               if (S_BREADY) begin
                  S_BVALID <= 1'b0;
                  wr_state <= WR_ACCEPT;
               end
            end
            default: wr_state <= WR_ACCEPT;
         endcase
      end
   end

   // Register storage: strobed update on an in-range write commit.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_commit && wr_in_range) begin
         regs[wr_idx] <= apply_strb(regs[wr_idx], wr_data, wr_strb);
      end
   end

   // Read channel: capture on AR handshake (pre-write value), hold until R taken.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         S_RVALID <= 1'b0;
         S_RDATA  <= '0;
         S_RRESP  <= 2'b00;
      end else if (ar_hs) begin
         S_RVALID <= 1'b1;
         S_RDATA  <= rd_in_range ? regs[rd_idx] : '0;
         S_RRESP  <= rd_in_range ? 2'b00 : 2'b10;
      end else if (S_RVALID && S_RREADY) begin
         S_RVALID <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Randomized bench for axi4_lite_slave_regfile against an array-based model.
module tb_axi4_lite_slave_regfile;
   logic        ACLK;
   logic        ARESETN;
   logic [31:0] S_AWADDR;
   logic        S_AWVALID;
   logic        S_AWREADY;
   logic [31:0] S_WDATA;
   logic [3:0]  S_WSTRB;
   logic        S_WVALID;
   logic        S_WREADY;
   logic [1:0]  S_BRESP;
   logic        S_BVALID;
   logic        S_BREADY;
   logic [31:0] S_ARADDR;
   logic        S_ARVALID;
   logic        S_ARREADY;
   logic [31:0] S_RDATA;
   logic [1:0]  S_RRESP;
   logic        S_RVALID;
   logic        S_RREADY;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] model [16];
   logic [31:0] rd;

   axi4_lite_slave_regfile #(.DATA_WIDTH(32), .ADDRESS(32), .NUM_REGS(16)) dut (
      .ACLK(ACLK), .ARESETN(ARESETN),
      .S_AWADDR(S_AWADDR), .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY),
      .S_WDATA(S_WDATA), .S_WSTRB(S_WSTRB), .S_WVALID(S_WVALID), .S_WREADY(S_WREADY),
      .S_BRESP(S_BRESP), .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
      .S_ARADDR(S_ARADDR), .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
      .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic bit in_window(input logic [31:0] a);
      return a < 32'd64;
   endfunction

   // Called and returns at #1 after a rising edge.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            input int b_stall);
      int         cyc;
      bit         aw_done, w_done, aw_fire, w_fire;
      logic [1:0] exp_resp;
      logic [1:0] resp0;
      aw_done = 0; w_done = 0; cyc = 0;
      exp_resp = in_window(addr) ? 2'b00 : 2'b10;
      S_BREADY = 1'b0;
      S_AWADDR = addr; S_WDATA = data; S_WSTRB = strb;
      while (!(aw_done && w_done)) begin
         S_AWVALID = (cyc >= aw_dly) && !aw_done;
         S_WVALID  = (cyc >= w_dly) && !w_done;
         aw_fire   = S_AWVALID && S_AWREADY;
         w_fire    = S_WVALID && S_WREADY;
         @(posedge ACLK); #1;
         aw_done |= aw_fire;
         w_done  |= w_fire;
         cyc++;
         if (!(aw_done && w_done)) begin
            check("bvalid_early", S_BVALID, 0);
            if (w_done && !aw_done) begin
               check("wready_after_w", S_WREADY, 0);
               check("awready_wait_aw", S_AWREADY, 1);
            end
            if (aw_done && !w_done) begin
               check("awready_after_aw", S_AWREADY, 0);
               check("wready_wait_w", S_WREADY, 1);
            end
         end
         if (cyc > 40) begin
            S_AWVALID = 0; S_WVALID = 0;
            check("wr_timeout", 0, 1);
            return;
         end
      end
      S_AWVALID = 0; S_WVALID = 0;
      if (in_window(addr)) begin
         for (int b = 0; b < 4; b++)
            if (strb[b]) model[addr / 4][8*b +: 8] = data[8*b +: 8];
      end
      check("bvalid", S_BVALID, 1);
      check("bresp", S_BRESP, exp_resp);
      check("awready_in_resp", S_AWREADY, 0);
      resp0 = S_BRESP;
      for (int s = 0; s < b_stall; s++) begin
         @(posedge ACLK); #1;
         check("bvalid_stall", S_BVALID, 1);
         check("bresp_stall", S_BRESP, resp0);
         check("aw_w_ready_stall", {S_AWREADY, S_WREADY}, 0);
      end
      S_BREADY = 1'b1;
      @(posedge ACLK); #1;
      S_BREADY = 1'b0;
      check("bvalid_clear", S_BVALID, 0);
   endtask

   // Called and returns at #1 after a rising edge.
   task automatic axi_read(input logic [31:0] addr, input int r_stall, output logic [31:0] data);
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
      int          cyc;
      bit          fired;
      exp_d = in_window(addr) ? model[addr / 4] : 32'h0;
      exp_r = in_window(addr) ? 2'b00 : 2'b10;
      S_ARADDR = addr; S_ARVALID = 1'b1; S_RREADY = 1'b0;
      fired = 0; cyc = 0;
      while (!fired && cyc < 40) begin
         fired = S_ARREADY;
         @(posedge ACLK); #1;
         cyc++;
      end
      S_ARVALID = 1'b0;
      data = 32'h0;
      if (!fired) begin
         check("ar_timeout", 0, 1);
         return;
      end
      check("rvalid", S_RVALID, 1);
      check("rdata", S_RDATA, exp_d);
      check("rresp", S_RRESP, exp_r);
      check("arready_busy", S_ARREADY, 0);
      data = S_RDATA;
      for (int s = 0; s < r_stall; s++) begin
         @(posedge ACLK); #1;
         check("rvalid_stall", S_RVALID, 1);
         check("rdata_stall", S_RDATA, exp_d);
         check("arready_stall", S_ARREADY, 0);
      end
      S_RREADY = 1'b1;
      @(posedge ACLK); #1;
      S_RREADY = 1'b0;
      check("rvalid_clear", S_RVALID, 0);
   endtask

   task automatic release_reset();
      @(negedge ACLK);
      ARESETN = 1'b1;
      #1;
      check("ready_low_after_release", {S_AWREADY, S_WREADY, S_ARREADY}, 0);
      @(posedge ACLK); #1;
      check("ready_high", {S_AWREADY, S_WREADY, S_ARREADY}, 3'b111);
   endtask

   initial begin
      logic [31:0] a, a2, d;
      logic [3:0]  st;
      ARESETN = 1'b0;
      S_AWADDR = 0; S_AWVALID = 0; S_WDATA = 0; S_WSTRB = 0; S_WVALID = 0;
      S_BREADY = 0; S_ARADDR = 0; S_ARVALID = 0; S_RREADY = 0;
      for (int i = 0; i < 16; i++) model[i] = 32'h0;

      repeat (3) @(posedge ACLK);
      #1;
      check("rst_valids", {S_BVALID, S_RVALID}, 0);
      check("rst_readys", {S_AWREADY, S_WREADY, S_ARREADY}, 0);
      check("rst_rdata", S_RDATA, 0);
      check("rst_resps", {S_BRESP, S_RRESP}, 0);
      release_reset();

      // Simultaneous AW/W, response one cycle later.
      axi_write(32'h8, 32'h0000_000A, 4'hF, 0, 0, 0);
      axi_read(32'h8, 0, rd);
      check("read_0x8", rd, 32'h0000_000A);

      // W three cycles ahead of AW.
      axi_write(32'h4, 32'h1234_5678, 4'hF, 3, 0, 0);
      axi_read(32'h4, 0, rd);
      check("read_0x4", rd, 32'h1234_5678);

      // Partial strobe merge.
      axi_write(32'h0, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
      axi_write(32'h0, 32'h0000_00AB, 4'h1, 0, 1, 0);
      axi_read(32'h0, 0, rd);
      check("strb_merge", rd, 32'hFFFF_FFAB);

      // Out-of-range access.
      axi_write(32'h40, 32'hDEAD_BEEF, 4'hF, 1, 0, 0);
      axi_read(32'h40, 0, rd);
      check("oor_read", rd, 32'h0);
      for (int i = 0; i < 16; i++) begin
         axi_read(i * 4, 0, rd);
      end

      // Back-pressure on B and R.
      axi_write(32'hC, 32'hCAFE_F00D, 4'hF, 0, 2, 5);
      axi_read(32'hC, 5, rd);
      check("stall_read", rd, 32'hCAFE_F00D);

      // Read and write commit on the same edge to the same register.
      fork
         axi_write(32'h8, 32'h5555_AAAA, 4'hF, 0, 0, 0);
         axi_read(32'h8, 0, rd);
      join
      check("read_pre_write", rd, 32'h0000_000A);
      axi_read(32'h8, 0, rd);
      check("read_post_write", rd, 32'h5555_AAAA);

      // Randomized mix of writes, reads and concurrent pairs.
      for (int n = 0; n < 60; n++) begin
         a  = $urandom_range(0, 19) * 4 + $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0) a = a | 32'h0001_0000;
         a2 = $urandom_range(0, 19) * 4;
         d  = $urandom;
         st = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 2))
            0: axi_write(a, d, st, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            1: axi_read(a, $urandom_range(0, 2), rd);
            default: fork
               axi_write(a, d, st, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
               axi_read(a2, $urandom_range(0, 2), rd);
            join
         endcase
      end

      // Sequential fill and readback.
      for (int i = 0; i < 10; i++) axi_write(i * 4, i + 2, 4'hF, 0, 0, 0);
      for (int i = 0; i < 10; i++) begin
         axi_read(i * 4, 0, rd);
         check("fill_read", rd, i + 2);
      end

      // Reset while a write response is pending.
      S_AWADDR = 32'h10; S_WDATA = 32'h7777_7777; S_WSTRB = 4'hF;
      S_AWVALID = 1'b1; S_WVALID = 1'b1; S_BREADY = 1'b0;
      @(posedge ACLK); #1;
      S_AWVALID = 1'b0; S_WVALID = 1'b0;
      check("bvalid_before_reset", S_BVALID, 1);
      #2;
      ARESETN = 1'b0;
      #1;
      check("bvalid_async_reset", S_BVALID, 0);
      check("readys_in_reset", {S_AWREADY, S_WREADY, S_ARREADY}, 0);
      for (int i = 0; i < 16; i++) model[i] = 32'h0;
      repeat (2) @(posedge ACLK);
      release_reset();
      for (int i = 0; i < 16; i++) begin
         axi_read(i * 4, 0, rd);
         check("after_reset_zero", rd, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
